// File: rtl/tour_logic_if.sv
// Command / replay bus of the 5x5 knight's tour solver.
// Master side: command logic and replay stage (go, start square, read index).
// Slave side:  the solver (one-hot move read-back, done pulse, status levels).
interface tour_logic_if;
    logic       go;         // start a solve; only honoured when the solver is idle
    logic [2:0] x_start;    // start column, 0 = west edge
    logic [2:0] y_start;    // start row, 0 = south edge
    logic [4:0] indx;       // move index to read back, 0..23
    logic [7:0] move;       // one-hot move stored at indx, 0 when indx >= 24
    logic       done;       // single-cycle pulse at the end of every solve
    logic       tour_vld;   // a complete tour is stored
    logic       fail;       // last solve produced no tour
    logic       busy;       // search in progress

    modport master (
        output go, x_start, y_start, indx,
        input  move, done, tour_vld, fail, busy
    );

    modport slave (
        input  go, x_start, y_start, indx,
        output move, done, tour_vld, fail, busy
    );
endinterface

// File: rtl/tour_logic.sv
// Backtracking knight's tour solver for a BOARD x BOARD board; moves stored one-hot, read back by index.
// Latency: data-dependent search; illegal start answers with done one cycle after go; read-back is combinational.
// Backpressure: none; go is ignored while busy, done is a single-cycle pulse, results hold until the next go.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, aborts any search in progress
//   tif      slave modport of tour_logic_if (go/x_start/y_start/indx in, move/done/tour_vld/fail/busy out)
module tour_logic #(
    parameter int BOARD     = 5,
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    tour_logic_if.slave tif
);
    localparam int SQUARES = BOARD * BOARD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POSS,
        S_MAKE,
        S_BACK,
        S_DONE
    } state_t;

    // Knight offsets indexed by one-hot bit position.
    function automatic int dx_of(input int b);
        case (b)
            0:       return 1;
            1:       return -1;
            2:       return -2;
            3:       return -2;
            4:       return -1;
            5:       return 1;
            6:       return 2;
            default: return 2;
        endcase
    endfunction

    function automatic int dy_of(input int b);
        case (b)
            0:       return 2;
            1:       return 2;
            2:       return 1;
            3:       return -1;
            4:       return -2;
            5:       return -2;
            6:       return -1;
            default: return 1;
        endcase
    endfunction

    // Two's-complement 3-bit offsets of a one-hot move. Used only for moves that
    // are known to land on the board, so modular 3-bit arithmetic is exact.
    function automatic logic [2:0] off_x(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r = r | 3'(dx_of(b));
        end
        return r;
    endfunction

    function automatic logic [2:0] off_y(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r = r | 3'(dy_of(b));
        end
        return r;
    endfunction

    function automatic logic [4:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'(int'(y) * BOARD + int'(x));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [SQUARES-1:0] board_q;
    logic [7:0]         last_move_q [NUM_MOVES];
    logic [7:0]         poss_q      [NUM_MOVES];
    logic [2:0]         cur_x_q, cur_y_q;
    logic [4:0]         move_num_q;
    logic [7:0]         try_q;
    logic               done_q, tour_vld_q, fail_q, busy_q;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic       start_bad;
    logic [7:0] poss_mask;
    logic [7:0] poss_cur;
    logic       hit;
    logic [2:0] take_x, take_y;
    logic [4:0] back_k;
    logic [7:0] back_mv;
    logic [2:0] back_x, back_y;

    // No 5x5 tour exists from an odd-parity square, so those are refused up front.
    assign start_bad = (tif.x_start > 3'(BOARD - 1)) ||
                       (tif.y_start > 3'(BOARD - 1)) ||
                       (tif.x_start[0] ^ tif.y_start[0]);

    // Landing squares are bounds-checked in full integer range before any
    // 3-bit arithmetic, so an off-board move can never alias onto a real square.
    always_comb begin : poss_gen
        int nx;
        int ny;
        nx        = 0;
        ny        = 0;
        poss_mask = '0;
        for (int b = 0; b < 8; b++) begin
            nx = int'(cur_x_q) + dx_of(b);
            ny = int'(cur_y_q) + dy_of(b);
            if (nx >= 0 && nx < BOARD && ny >= 0 && ny < BOARD) begin
                if (!board_q[5'(ny * BOARD + nx)]) poss_mask[b] = 1'b1;
            end
        end
    end

    assign poss_cur = poss_q[move_num_q];
    assign hit      = |(poss_cur & try_q);
    assign take_x   = cur_x_q + off_x(try_q);
    assign take_y   = cur_y_q + off_y(try_q);
    assign back_k   = move_num_q - 5'd1;
    assign back_mv  = last_move_q[back_k];
    assign back_x   = cur_x_q - off_x(back_mv);
    assign back_y   = cur_y_q - off_y(back_mv);

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    logic start_solve, start_fail, take, finish_ok, step_try, back_step, exhaust;

    always_comb begin
        state_d     = state_q;
        start_solve = 1'b0;
        start_fail  = 1'b0;
        take        = 1'b0;
        finish_ok   = 1'b0;
        step_try    = 1'b0;
        back_step   = 1'b0;
        exhaust     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (tif.go) begin
                    if (start_bad) begin
                        start_fail = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        start_solve = 1'b1;
                        state_d     = S_POSS;
                    end
                end
            end
            S_POSS: begin
                state_d = S_MAKE;
            end
            S_MAKE: begin
                if (hit) begin
                    take = 1'b1;
                    if (move_num_q == 5'(NUM_MOVES - 1)) begin
                        finish_ok = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_POSS;
                    end
                end else if (try_q != 8'h80) begin
                    step_try = 1'b1;
                end else begin
                    state_d = S_BACK;
                end
            end
            S_BACK: begin
                if (move_num_q == 5'd0) begin
                    exhaust = 1'b1;
                    state_d = S_DONE;
                end else begin
                    back_step = 1'b1;
                    // A retracted move that was already the last candidate
                    // leaves nothing to try at that level: keep unwinding.
                    if (back_mv == 8'h80) state_d = S_BACK;
                    else                  state_d = S_MAKE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            board_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            move_num_q <= '0;
            try_q      <= '0;
            done_q     <= 1'b0;
            tour_vld_q <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                last_move_q[i] <= '0;
                poss_q[i]      <= '0;
            end
        end else begin
            done_q <= 1'b0;

            // Refused start: stored moves are left as they were.
            if (start_fail) begin
                done_q     <= 1'b1;
                fail_q     <= 1'b1;
                tour_vld_q <= 1'b0;
            end

            if (start_solve) begin
                board_q                                <= '0;
                board_q[sq_idx(tif.x_start, tif.y_start)] <= 1'b1;
                cur_x_q                                <= tif.x_start;
                cur_y_q                                <= tif.y_start;
                move_num_q                             <= '0;
                tour_vld_q                             <= 1'b0;
                fail_q                                 <= 1'b0;
                busy_q                                 <= 1'b1;
            end

            if (state_q == S_POSS) begin
                poss_q[move_num_q] <= poss_mask;
                try_q              <= 8'h01;
            end

            if (take) begin
                last_move_q[move_num_q]  <= try_q;
                cur_x_q                  <= take_x;
                cur_y_q                  <= take_y;
                board_q[sq_idx(take_x, take_y)] <= 1'b1;
                move_num_q               <= move_num_q + 5'd1;
                if (finish_ok) begin
                    done_q     <= 1'b1;
                    tour_vld_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            end

            if (step_try) try_q <= try_q << 1;

            // Retract one move; poss_q[k] still holds the candidate mask for
            // that level, so the search resumes at the next higher bit.
            if (back_step) begin
                board_q[sq_idx(cur_x_q, cur_y_q)] <= 1'b0;
                cur_x_q    <= back_x;
                cur_y_q    <= back_y;
                move_num_q <= back_k;
                try_q      <= back_mv << 1;
            end

            if (exhaust) begin
                done_q <= 1'b1;
                fail_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tif.move     = (tif.indx < 5'(NUM_MOVES)) ? last_move_q[tif.indx] : 8'h00;
    assign tif.done     = done_q;
    assign tif.tour_vld = tour_vld_q;
    assign tif.fail     = fail_q;
    assign tif.busy     = busy_q;
endmodule

// File: tb/tb_tour_logic.sv
// Directed bench for tour_logic: start outcomes are queued when go is driven
// and checked when done pulses; tours are replayed move by move on a bench board.
module tb_tour_logic;
    localparam int NUM_MOVES    = 24;
    localparam int SOLVE_BUDGET = 300000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tour_logic_if tif ();

    tour_logic #(.BOARD(5), .NUM_MOVES(NUM_MOVES)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        logic  vld;
        logic  fl;
    } exp_t;
    exp_t sb[$];

    int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    logic [7:0] rd_tour [NUM_MOVES];
    logic [7:0] tour_a  [NUM_MOVES];
    logic [7:0] tour_b  [NUM_MOVES];
    int         solve_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic start_go(input int x, input int y, input bit push,
                            input string tag, input logic vld, input logic fl);
        exp_t e;
        @(negedge clk);
        tif.go      = 1'b1;
        tif.x_start = 3'(x);
        tif.y_start = 3'(y);
        if (push) begin
            e.tag = tag;
            e.vld = vld;
            e.fl  = fl;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag, input bit hold, output int cycles);
        exp_t e;
        bit   seen;
        int   cyc;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < SOLVE_BUDGET && !seen) begin
            @(negedge clk);
            if (!hold) tif.go = 1'b0;
            cyc++;
            if (tif.done === 1'b1) seen = 1'b1;
        end
        tif.go = 1'b0;
        cycles = cyc;
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (!seen) finish_run();
        chk({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_tour_vld"}, 32'(tif.tour_vld), 32'(e.vld));
            chk({e.tag, "_fail"},     32'(tif.fail),     32'(e.fl));
        end
        chk({tag, "_busy_at_done"}, 32'(tif.busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse_1cyc"}, 32'(tif.done), 0);
    endtask

    task automatic read_tour();
        for (int i = 0; i < NUM_MOVES; i++) begin
            @(negedge clk);
            tif.indx = 5'(i);
            #1;
            rd_tour[i] = tif.move;
        end
    endtask

    // Walk the stored moves from the start square on an independent board.
    task automatic replay(input string tag, input int sx, input int sy);
        int vis[25];
        int x, y, b, nvis;
        bit ok;
        foreach (vis[i]) vis[i] = 0;
        x    = sx;
        y    = sy;
        ok   = 1'b1;
        nvis = 1;
        vis[sy * 5 + sx] = 1;
        read_tour();
        for (int i = 0; i < NUM_MOVES; i++) begin
            if (!$onehot(rd_tour[i])) begin
                ok = 1'b0;
            end else begin
                b = 0;
                for (int j = 0; j < 8; j++) if (rd_tour[i][j]) b = j;
                x = x + DX[b];
                y = y + DY[b];
                if (x < 0 || x > 4 || y < 0 || y > 4) ok = 1'b0;
                else if (vis[y * 5 + x] != 0)         ok = 1'b0;
                else begin
                    vis[y * 5 + x] = 1;
                    nvis++;
                end
            end
        end
        chk({tag, "_legal_moves"},     32'(ok),   1);
        chk({tag, "_squares_visited"}, 32'(nvis), 25);
    endtask

    initial begin
        int diff;
        int cyc_tmp;
        tif.go      = 1'b0;
        tif.x_start = 3'd0;
        tif.y_start = 3'd0;
        tif.indx    = 5'd0;
        rst         = 1'b1;

        // Reset with go held: nothing may start.
        tif.go      = 1'b1;
        tif.x_start = 3'd2;
        tif.y_start = 3'd2;
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(tif.busy),     0);
        chk("rst_done",     32'(tif.done),     0);
        chk("rst_tour_vld", 32'(tif.tour_vld), 0);
        chk("rst_fail",     32'(tif.fail),     0);
        for (int i = 0; i < 32; i++) begin
            tif.indx = 5'(i);
            #1;
            chk($sformatf("rst_move_%0d", i), 32'(tif.move), 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        tif.go = 1'b0;

        // Solve from the centre.
        start_go(2, 2, 1'b1, "c22", 1'b1, 1'b0);
        @(negedge clk);
        tif.go = 1'b0;
        chk("c22_busy_rises", 32'(tif.busy), 1);
        wait_done("c22", 1'b0, solve_cycles);
        replay("c22", 2, 2);

        // Solve from a corner and keep the move list.
        start_go(0, 0, 1'b1, "c00a", 1'b1, 1'b0);
        wait_done("c00a", 1'b0, cyc_tmp);
        replay("c00a", 0, 0);
        tour_a = rd_tour;
        for (int i = 24; i < 32; i++) begin
            @(negedge clk);
            tif.indx = 5'(i);
            #1;
            chk($sformatf("oob_move_%0d", i), 32'(tif.move), 0);
        end

        // Restart from DONE with go held for the whole solve; a changed start
        // square while busy must not leak into the search.
        start_go(0, 0, 1'b1, "c00b", 1'b1, 1'b0);
        @(negedge clk);
        chk("c00b_vld_drops", 32'(tif.tour_vld), 0);
        chk("c00b_busy",      32'(tif.busy),     1);
        tif.x_start = 3'd1;
        wait_done("c00b", 1'b1, cyc_tmp);
        replay("c00b", 0, 0);
        diff = 0;
        for (int i = 0; i < NUM_MOVES; i++) if (rd_tour[i] !== tour_a[i]) diff++;
        chk("c00b_same_tour", 32'(diff), 0);
        tour_b = rd_tour;

        // Odd-parity start: immediate failure, stored moves kept.
        start_go(1, 0, 1'b1, "odd10", 1'b0, 1'b1);
        wait_done("odd10", 1'b0, cyc_tmp);
        chk("odd10_latency", 32'(cyc_tmp), 1);
        read_tour();
        diff = 0;
        for (int i = 0; i < NUM_MOVES; i++) if (rd_tour[i] !== tour_b[i]) diff++;
        chk("odd10_moves_kept", 32'(diff), 0);

        // Off-board start.
        start_go(5, 2, 1'b1, "off52", 1'b0, 1'b1);
        wait_done("off52", 1'b0, cyc_tmp);
        chk("off52_latency", 32'(cyc_tmp), 1);

        // Abort a search with reset.
        start_go(2, 2, 1'b0, "abort", 1'b0, 1'b0);
        @(negedge clk);
        tif.go = 1'b0;
        repeat (998) @(negedge clk);
        if (solve_cycles > 1005) chk("abort_busy_before_rst", 32'(tif.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",     32'(tif.busy),     0);
        chk("abort_done",     32'(tif.done),     0);
        chk("abort_tour_vld", 32'(tif.tour_vld), 0);
        chk("abort_fail",     32'(tif.fail),     0);
        rst = 1'b0;
        for (int i = 0; i < NUM_MOVES; i += 5) begin
            @(negedge clk);
            tif.indx = 5'(i);
            #1;
            chk($sformatf("abort_move_%0d", i), 32'(tif.move), 0);
        end

        // Opposite corner, with a stray go pulse during the search.
        start_go(4, 4, 1'b1, "c44", 1'b1, 1'b0);
        @(negedge clk);
        tif.go = 1'b0;
        repeat (30) @(negedge clk);
        chk("c44_busy_mid", 32'(tif.busy), 1);
        tif.go      = 1'b1;
        tif.x_start = 3'd2;
        tif.y_start = 3'd2;
        wait_done("c44", 1'b0, cyc_tmp);
        replay("c44", 4, 4);

        chk("sb_drained", 32'(sb.size()), 0);
        finish_run();
    end
endmodule

// File: doc/tour_logic.md
Name: tour_logic

Overview:
- Backtracking Knight's Tour solver for the 5x5 board.
- Given a start square, it searches for a 24-move open tour and stores each move as an 8-bit one-hot code.
- After the solve it serves the moves by index to the tour replay stage, which reads `move`/`indx` as `move`/`mv_indx` and uses `done` as `start_tour`.
- Sits directly upstream of the replay stage; the command interface triggers it with `go` and the start coordinates.

Parameters:
- BOARD, 5, board edge length in squares; coordinates range 0..BOARD-1.
- NUM_MOVES, 24, tour length in moves (BOARD*BOARD-1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- go  in  1  start a solve; sampled only in IDLE or DONE
- x_start  in  3  start column; 0 = west edge, +x = east
- y_start  in  3  start row; 0 = south edge, +y = north
- indx  in  5  move index to read, 0..23
- move  out  8  one-hot move stored at `indx`
- done  out  1  one-cycle pulse when a solve finishes, success or fail
- tour_vld  out  1  level; a valid tour is stored
- fail  out  1  level; the last solve found no tour
- busy  out  1  level; solver is searching

Behaviour:
- Move encoding (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Storage:
  - 25-bit visited board.
  - last_move[0:23], 8 bits each.
  - poss[0:23], 8 bits each.
  - 3-bit cur_x, 3-bit cur_y.
  - 5-bit move_num.
  - 8-bit one-hot try.
- `move` = last_move[indx], combinational. For indx >= 24, `move` = 0.
- Reset (rst high at a clk edge): state IDLE; board, last_move, poss and move_num cleared; done = tour_vld = fail = busy = 0; `move` reads 0.
- IDLE / DONE state behaviour:
  - go is sampled here.
  - If x_start > 4, y_start > 4, or x_start+y_start is odd (no 5x5 tour exists): next cycle done = 1 for one cycle, fail = 1, tour_vld = 0, enter DONE, stored moves untouched.
  - Otherwise: clear board, then mark the start square; cur = start; move_num = 0; tour_vld = fail = 0; busy = 1; enter POSS.
- POSS: poss[move_num] gets the mask of moves whose landing square is on-board and unvisited; try = 8'h01; enter MAKE.
- MAKE (one candidate per cycle):
  - If poss[move_num] & try is nonzero:
    - last_move[move_num] = try.
    - cur += offset(try); mark the new square visited.
    - move_num++.
    - If the new move_num == 24: enter DONE with done pulse, tour_vld = 1, busy = 0.
    - Else: enter POSS.
  - Else if try != 8'h80: try <<= 1.
  - Else: enter BACK.
- BACK:
  - If move_num == 0: search exhausted; enter DONE with done pulse, fail = 1, busy = 0. Unreachable for even-parity starts, but must be implemented.
  - Else, with k = move_num-1:
    - Unmark cur.
    - cur -= offset(last_move[k]).
    - move_num = k.
    - If last_move[k] == 8'h80: remain in BACK.
    - Else: try = last_move[k] << 1, enter MAKE. poss[k] is reused without recompute.
- go while busy: ignored.
- go in DONE: restarts as from IDLE. tour_vld drops the cycle after go is sampled.
- done is a pulse only, so the replay stage returns to its IDLE without retriggering.
- rst mid-search: aborts immediately to reset values; no partial tour is flagged valid.
- Solve latency is data-dependent and unbounded by this spec. The search order (bit0 first) is fixed, so a given start always yields the same tour.
- Coordinate arithmetic is 3-bit signed-safe: bounds are checked before the add, so no wrap-around ever marks a square.

Test Plan:
- rst with go = 1 held: no state change; busy = done = 0; move = 0 for all indx.
- go, start (2,2) → busy high until a single done pulse; then tour_vld = 1, fail = 0. Bench replays last_move[0..23] from (2,2): every square is on-board and all 25 are visited exactly once.
- go, start (0,0) → same replay check. A second go from (0,0) gives a bit-identical move list. indx = 24..31 reads 0.
- go, start (1,0) (odd parity) → done pulse 1 cycle later, fail = 1, busy never rises, tour_vld = 0. go, start (5,2) → same response.
- go from (2,2), then rst after 1000 cycles → all outputs at reset values next cycle. go from (4,4) then completes with a valid replay.
- go asserted continuously through a solve → exactly one done pulse per solve. Pulse go at busy = 1 → no effect on the final tour.
